regset_front: RTL and testbench

Write/read front end placed directly upstream of the 64-entry RudolV register set, which is built on BRAM with no preinit. After reset it sweeps every entry to zero. It then passes pipeline write requests and read addresses through to the register set. It also corrects the register set's read-during-write behaviour: a same-cycle write to the address being read returns the old BRAM content, and this block forwards the new write data instead.

---
 rtl/regset_front_if.sv | 45 ++++
 rtl/regset_front.sv | 80 ++++++++
 tb/tb_regset_front.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regset_front_if.sv
// regset_front_if: pipeline-side and register-set-side signals of the
// register set front end.
//   pipeline side: busy, we/wa/wd/wg write request, ra1/ra2 -> rd*/rg*
//   register-set side: rs_we/rs_wa/rs_wd/rs_wg, rs_ra*, rs_rd*/rs_rg*
// slave is the front end itself; master is the pipeline plus register set.
interface regset_front_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 6
);
    logic             busy;
    logic             we;
    logic [ADDR-1:0]  wa;
    logic [WIDTH-1:0] wd;
    logic             wg;
    logic [ADDR-1:0]  ra1;
    logic [ADDR-1:0]  ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rg1;
    logic             rg2;
    logic             rs_we;
    logic [ADDR-1:0]  rs_wa;
    logic [WIDTH-1:0] rs_wd;
    logic             rs_wg;
    logic [ADDR-1:0]  rs_ra1;
    logic [ADDR-1:0]  rs_ra2;
    logic [WIDTH-1:0] rs_rd1;
    logic [WIDTH-1:0] rs_rd2;
    logic             rs_rg1;
    logic             rs_rg2;

    modport slave (
        output busy, rd1, rd2, rg1, rg2,
        output rs_we, rs_wa, rs_wd, rs_wg, rs_ra1, rs_ra2,
        input  we, wa, wd, wg, ra1, ra2,
        input  rs_rd1, rs_rd2, rs_rg1, rs_rg2
    );

    modport master (
        input  busy, rd1, rd2, rg1, rg2,
        input  rs_we, rs_wa, rs_wd, rs_wg, rs_ra1, rs_ra2,
        output we, wa, wd, wg, ra1, ra2,
        output rs_rd1, rs_rd2, rs_rg1, rs_rg2
    );
endinterface

// File: rtl/regset_front.sv
// regset_front: zero-init sweep, write/read pass-through and
// read-during-write forwarding in front of the BRAM register set.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : regset_front_if.slave (pipeline and register-set ports)
module regset_front #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 6
) (
    input  logic          clk,
    input  logic          rst,
    regset_front_if.slave bus
);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR-1:0] CNT_ONE  = {{(ADDR-1){1'b0}}, 1'b1};
    localparam logic [ADDR-1:0] CNT_LAST = {ADDR{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [ADDR-1:0]  cnt_q, cnt_d;
    logic             init_q;
    logic             fwd1_q, fwd2_q;
    logic [WIDTH-1:0] wd_q;
    logic             wg_q;
    logic             run;
    logic             fwd1_d, fwd2_d;

    assign run = (state_q == S_RUN);

    // cnt wraps to 0 on the last sweep edge and then holds in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                state_d = S_RUN;
            end
        end
    end

    // BRAM returns old data on a same-cycle write; remember to override.
    // Address 0 is never forwarded so it keeps reading as zero.
    assign fwd1_d = run && bus.we && (bus.wa == bus.ra1) && (bus.ra1 != '0);
    assign fwd2_d = run && bus.we && (bus.wa == bus.ra2) && (bus.ra2 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            init_q  <= 1'b1;
            fwd1_q  <= 1'b0;
            fwd2_q  <= 1'b0;
            wd_q    <= '0;
            wg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= !run;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
            wd_q    <= bus.wd;
            wg_q    <= bus.wg;
        end
    end

    assign bus.busy   = !run;
    assign bus.rs_we  = run ? bus.we : 1'b1;
    assign bus.rs_wa  = run ? bus.wa : cnt_q;
    assign bus.rs_wd  = run ? bus.wd : '0;
    assign bus.rs_wg  = run && bus.wg;
    assign bus.rs_ra1 = bus.ra1;
    assign bus.rs_ra2 = bus.ra2;

    // reads issued during the sweep may see unswept BRAM: force zero
    assign bus.rd1 = init_q ? '0 : (fwd1_q ? wd_q : bus.rs_rd1);
    assign bus.rd2 = init_q ? '0 : (fwd2_q ? wd_q : bus.rs_rd2);
    assign bus.rg1 = !init_q && (fwd1_q ? wg_q : bus.rs_rg1);
    assign bus.rg2 = !init_q && (fwd2_q ? wg_q : bus.rs_rg2);
endmodule

// File: tb/tb_regset_front.sv
// tb_regset_front: random and directed stimulus against an architectural
// register-file model, with a BRAM register set that powers up random.
module tb_regset_front;
    localparam int W = 32;
    localparam int A = 6;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regset_front_if #(.WIDTH(W), .ADDR(A)) bus ();

    regset_front #(.WIDTH(W), .ADDR(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // register set: registered read, old data on read-during-write,
    // address 0 always reads zero, random power-up content
    logic [W-1:0] bram [N];
    logic         gram [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            bram[i] <= $urandom;
            gram[i] <= 1'($urandom);
        end
    end

    always @(posedge clk) begin
        bus.rs_rd1 <= (bus.rs_ra1 == '0) ? '0 : bram[bus.rs_ra1];
        bus.rs_rd2 <= (bus.rs_ra2 == '0) ? '0 : bram[bus.rs_ra2];
        bus.rs_rg1 <= (bus.rs_ra1 == '0) ? 1'b0 : gram[bus.rs_ra1];
        bus.rs_rg2 <= (bus.rs_ra2 == '0) ? 1'b0 : gram[bus.rs_ra2];
        if (bus.rs_we) begin
            bram[bus.rs_wa] <= bus.rs_wd;
            gram[bus.rs_wa] <= bus.rs_wg;
        end
    end

    // architectural model: what the pipeline must observe
    logic [W-1:0] m_mem [N];
    logic         m_g   [N];
    bit           m_busy;
    int           m_cnt;
    logic [W-1:0] e_rd1, e_rd2;
    logic         e_rg1, e_rg2;
    bit           leak7;

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(bit we, logic [A-1:0] wa, logic [W-1:0] wd,
                          bit wg, logic [A-1:0] ra1, logic [A-1:0] ra2);
        bus.we  = we;
        bus.wa  = wa;
        bus.wd  = wd;
        bus.wg  = wg;
        bus.ra1 = ra1;
        bus.ra2 = ra2;
    endtask

    function automatic logic [A-1:0] raddr();
        if ($urandom_range(0, 3) == 0) return A'($urandom_range(0, N - 1));
        return A'($urandom_range(0, 7));
    endfunction

    // one clock: check combinational ports, advance model, check reads
    task automatic step();
        #1;
        chk("busy", W'(bus.busy), W'(m_busy));
        chk("rs_ra1", W'(bus.rs_ra1), W'(bus.ra1));
        chk("rs_ra2", W'(bus.rs_ra2), W'(bus.ra2));
        if (m_busy) begin
            chk("sweep_we", W'(bus.rs_we), W'(1));
            chk("sweep_wa", W'(bus.rs_wa), W'(m_cnt));
            chk("sweep_wd", bus.rs_wd, '0);
            chk("sweep_wg", W'(bus.rs_wg), W'(0));
            if (bus.rs_we && bus.rs_wa == 7 && bus.rs_wd != 0) leak7 = 1;
        end else begin
            chk("pass_we", W'(bus.rs_we), W'(bus.we));
            chk("pass_wa", W'(bus.rs_wa), W'(bus.wa));
            chk("pass_wd", bus.rs_wd, bus.wd);
            chk("pass_wg", W'(bus.rs_wg), W'(bus.wg));
        end
        @(posedge clk);
        if (m_busy) begin
            e_rd1 = '0;
            e_rd2 = '0;
            e_rg1 = 1'b0;
            e_rg2 = 1'b0;
            m_cnt++;
            if (m_cnt == N) begin
                m_busy = 0;
                m_cnt  = 0;
            end
        end else begin
            if (bus.we) begin
                m_mem[bus.wa] = bus.wd;
                m_g[bus.wa]   = bus.wg;
            end
            e_rd1 = (bus.ra1 == '0) ? '0 : m_mem[bus.ra1];
            e_rd2 = (bus.ra2 == '0) ? '0 : m_mem[bus.ra2];
            e_rg1 = (bus.ra1 == '0) ? 1'b0 : m_g[bus.ra1];
            e_rg2 = (bus.ra2 == '0) ? 1'b0 : m_g[bus.ra2];
        end
        @(negedge clk);
        chk("rd1", bus.rd1, e_rd1);
        chk("rd2", bus.rd2, e_rd2);
        chk("rg1", W'(bus.rg1), W'(e_rg1));
        chk("rg2", W'(bus.rg2), W'(e_rg2));
    endtask

    // called at a negedge; leaves rst low at the following negedge
    task automatic do_reset();
        rst = 1'b1;
        m_busy = 1;
        m_cnt  = 0;
        for (int i = 0; i < N; i++) begin
            m_mem[i] = '0;
            m_g[i]   = 1'b0;
        end
        #1;
        chk("rst_busy", W'(bus.busy), W'(1));
        chk("rst_we", W'(bus.rs_we), W'(1));
        chk("rst_wa", W'(bus.rs_wa), W'(0));
        chk("rst_wd", bus.rs_wd, '0);
        chk("rst_rd1", bus.rd1, '0);
        chk("rst_rd2", bus.rd2, '0);
        chk("rst_rg1", W'(bus.rg1), W'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sweep(bit inject);
        int n = 0;
        leak7 = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            set_in(inject && i == 3, 7, 32'h55, 1'b1, raddr(), raddr());
            step();
            n++;
        end
        chk("sweep_len", W'(n), W'(N));
        chk("sweep_leak7", W'(leak7), W'(0));
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();
        run_sweep(1);

        for (int a = 1; a < N; a++) begin
            set_in(0, 0, 0, 0, A'(a), A'(N - a));
            step();
            chk("init_rd1", bus.rd1, '0);
            chk("init_rg2", W'(bus.rg2), W'(0));
        end
        set_in(0, 0, 0, 0, 7, 7);
        step();
        chk("rd7_after_init", bus.rd1, '0);

        set_in(1, 5, 32'hDEADBEEF, 1, 5, 5);
        step();
        chk("fwd_rd1", bus.rd1, 32'hDEADBEEF);
        chk("fwd_rd2", bus.rd2, 32'hDEADBEEF);
        chk("fwd_rg1", W'(bus.rg1), W'(1));
        chk("fwd_rg2", W'(bus.rg2), W'(1));
        set_in(0, 0, 0, 0, 5, 5);
        step();
        chk("bram_rd1", bus.rd1, 32'hDEADBEEF);

        set_in(1, 0, 32'h1234, 1, 0, 0);
        step();
        chk("x0_rd1", bus.rd1, '0);
        chk("x0_rg1", W'(bus.rg1), W'(0));

        for (int i = 0; i < 1500; i++) begin
            set_in(1'($urandom), raddr(), $urandom, 1'($urandom),
                   raddr(), raddr());
            step();
        end

        set_in(1, 9, 32'hAA, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 9, 0);
        step();
        chk("rd9_before_rst", bus.rd1, 32'hAA);
        do_reset();
        run_sweep(0);
        set_in(0, 0, 0, 0, 9, 9);
        step();
        chk("rd9_after_rst", bus.rd1, '0);
        chk("rd9_after_rst2", bus.rd2, '0);

        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom), raddr(), $urandom, 1'($urandom),
                   raddr(), raddr());
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
